id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus operand selection for the 32-bit ALU.
//  - Captures decoded operands and control from ID; drives the ALU opcode and A/B operands.
//  - Resolves RAW hazards: forwards from EX/MEM and MEM/WB, and detects load-use hazards.
//  - Stalls upstream and inserts bubbles; applies flushes from branch resolution.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register address width
// PORTS
//  clk                 in   1       pipeline clock, rising edge
//  reset               in   1       synchronous, active-high
//  flush_i             in   1       kill the instruction entering EX (taken branch/jump)
//  id_valid_i          in   1       ID holds a real instruction
//  id_rs1_addr_i       in   REG_AW  source 1 index
//  id_rs2_addr_i       in   REG_AW  source 2 index
//  id_rd_addr_i        in   REG_AW  destination index
//  id_rs1_data_i       in   XLEN    register-file read 1
//  id_rs2_data_i       in   XLEN    register-file read 2
//  id_imm_i            in   XLEN    sign-extended immediate
//  id_alu_op_i         in   4       ALU operation code
//  id_alu_src_i        in   1       1: B operand = immediate
//  id_mem_read_i       in   1       instruction is a load
//  id_reg_write_i      in   1       instruction writes rd
//  exmem_reg_write_i   in   1       EX/MEM writes its rd
//  exmem_rd_addr_i     in   REG_AW  EX/MEM destination
//  exmem_alu_result_i  in   XLEN    EX/MEM ALU result
//  memwb_reg_write_i   in   1       MEM/WB writes its rd
//  memwb_rd_addr_i     in   REG_AW  MEM/WB destination
//  memwb_wb_data_i     in   XLEN    MEM/WB write-back data
//  stall_o             out  1       hold PC and IF/ID this cycle
//  ex_valid_o          out  1       EX holds a real instruction
//  ex_alu_op_o         out  4       to ALU operation select
//  ex_a_o              out  XLEN    to ALU A operand (after forwarding)
//  ex_b_o              out  XLEN    to ALU B operand (imm or forwarded rs2)
//  ex_store_data_o     out  XLEN    forwarded rs2, for stores
//  ex_rd_addr_o        out  REG_AW  destination carried to EX/MEM
//  ex_mem_read_o       out  1       load flag carried to EX/MEM
//  ex_reg_write_o      out  1       write flag carried to EX/MEM
// BEHAVIOUR
//  - Reset: all EX registers cleared to 0; ex_valid_o/ex_reg_write_o/ex_mem_read_o = 0; ex_alu_op_o = ADD (0000).
//  - Latency: ID fields appear on ex_* one clock after capture; forwarding muxes on ex_a/b/store are combinational.
//  - Register load, priority per clock: reset > flush_i > stall_o > normal capture.
//    - flush_i or stall_o: load a bubble (valid/reg_write/mem_read = 0, rd = 0, op = ADD, data = 0).
//  - Load-use: stall_o = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    - Combinational; lasts exactly 1 cycle per hazard.
//    - flush_i in the same cycle suppresses stall_o.
//  - Forwarding, per source, registered rs (nonzero index):
//    - EX/MEM match with exmem_reg_write -> exmem_alu_result.
//    - else MEM/WB match with memwb_reg_write -> memwb_wb_data.
//    - else registered read data.
//    - Index x0 is never forwarded.
//  - ex_b_o = imm if registered alu_src, else forwarded rs2; ex_store_data_o is always forwarded rs2.
//  - Register file is write-before-read, so the WB->ID distance needs no handling here.
// CONFIGURATION
//  - FWD_EN defined: forwarding as above.
//  - FWD_EN undefined: forwarding inputs ignored, operands come straight from the register.
//    - stall_o also asserts when an ID source (nonzero) matches ex_rd with ex_reg_write,
//      or exmem_rd_addr_i with exmem_reg_write_i.
// STRUCTURE
//  - Package riscv_pkg: ALU op localparams (ADD 0000 SUB 0001 AND 0010 OR 0011 XOR 0100
//    SLL 0101 SRL 0110), forward-select codes (FWD_REG 00, FWD_MEMWB 01, FWD_EXMEM 10), XLEN, REG_AW.
//  - Sub-module forward_unit: index compare + select, instantiated once per source (rs1, rs2).
// TESTING
//  1. reset=1 two clocks, ID driving valid data -> all ex_* = 0, stall_o=0; first capture one clock after release.
//  2. ADD x3,x1,x2 then ADD x4,x3,x3 (exmem_alu_result=0x0000_0010) -> ex_a_o=ex_b_o=0x10.
//  3. x5 matched in both EX/MEM (0xAA) and MEM/WB (0xBB) -> 0xAA; rd=x0 with result 0xFF -> not forwarded, reg value used.
//  4. LW x6 in EX, ID reads x6 -> stall_o=1 one cycle, bubble in EX; MEM/WB forward then supplies load data.
//  5. flush_i=1 together with a load-use hazard -> stall_o=0, bubble loaded, ex_valid_o=0 next clock.
//  6. FWD_EN undefined, back-to-back dependent ADDs -> stall_o=1 for two cycles, correct operands after the register-file write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared widths, ALU opcodes, forward-select codes and the ID/EX register layout
// for the operand stage.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  // An all-zero value of this struct is a bubble (op = ALU_ADD, no side effects).
  typedef struct packed {
    logic              valid;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              reg_write;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
  } ex_reg_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, bypass sources and EX-side outputs.
// master = surrounding pipeline, slave = the operand stage.
interface id_ex_operand_stage_if;
  import riscv_pkg::*;

  logic              flush_i;
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_addr_i;
  logic [REG_AW-1:0] id_rs2_addr_i;
  logic [REG_AW-1:0] id_rd_addr_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [3:0]        id_alu_op_i;
  logic              id_alu_src_i;
  logic              id_mem_read_i;
  logic              id_reg_write_i;
  logic              exmem_reg_write_i;
  logic [REG_AW-1:0] exmem_rd_addr_i;
  logic [XLEN-1:0]   exmem_alu_result_i;
  logic              memwb_reg_write_i;
  logic [REG_AW-1:0] memwb_rd_addr_i;
  logic [XLEN-1:0]   memwb_wb_data_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [3:0]        ex_alu_op_o;
  logic [XLEN-1:0]   ex_a_o;
  logic [XLEN-1:0]   ex_b_o;
  logic [XLEN-1:0]   ex_store_data_o;
  logic [REG_AW-1:0] ex_rd_addr_o;
  logic              ex_mem_read_o;
  logic              ex_reg_write_o;

  modport master (
    output flush_i, id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i, id_alu_src_i,
           id_mem_read_i, id_reg_write_i, exmem_reg_write_i, exmem_rd_addr_i,
           exmem_alu_result_i, memwb_reg_write_i, memwb_rd_addr_i, memwb_wb_data_i,
    input  stall_o, ex_valid_o, ex_alu_op_o, ex_a_o, ex_b_o, ex_store_data_o,
           ex_rd_addr_o, ex_mem_read_o, ex_reg_write_o
  );

  modport slave (
    input  flush_i, id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i, id_alu_src_i,
           id_mem_read_i, id_reg_write_i, exmem_reg_write_i, exmem_rd_addr_i,
           exmem_alu_result_i, memwb_reg_write_i, memwb_rd_addr_i, memwb_wb_data_i,
    output stall_o, ex_valid_o, ex_alu_op_o, ex_a_o, ex_b_o, ex_store_data_o,
           ex_rd_addr_o, ex_mem_read_o, ex_reg_write_o
  );

endinterface

// File: rtl/forward_unit.sv
// Bypass select for one ALU source: EX/MEM beats MEM/WB beats the registered read.
// With EN = 0 the registered read data always passes through.
module forward_unit
  import riscv_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]   memwb_data,
  output logic [XLEN-1:0]   data
);

  fwd_sel_t sel;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel = FWD_REG;
    if (EN && rs_addr != '0) begin
      if (exmem_reg_write && exmem_rd_addr == rs_addr) begin
        sel = FWD_EXMEM;
      end else if (memwb_reg_write && memwb_rd_addr == rs_addr) begin
        sel = FWD_MEMWB;
      end
    end
  end

  always_comb begin
    data = rs_data;
    case (sel)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      default:   data = rs_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush bubbles.
// Define FWD_EN to enable bypassing; otherwise RAW hazards on EX and EX/MEM stall.
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  id_ex_operand_stage_if.slave bus
);

`ifdef FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  ex_reg_t         ex_q;
  ex_reg_t         ex_d;
  logic            load_use;
  logic            dep_stall;
  logic            stall;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = bus.id_valid_i;
    ex_d.alu_op    = bus.id_alu_op_i;
    ex_d.alu_src   = bus.id_alu_src_i;
    ex_d.mem_read  = bus.id_mem_read_i;
    ex_d.reg_write = bus.id_reg_write_i;
    ex_d.rs1_addr  = bus.id_rs1_addr_i;
    ex_d.rs2_addr  = bus.id_rs2_addr_i;
    ex_d.rd_addr   = bus.id_rd_addr_i;
    ex_d.rs1_data  = bus.id_rs1_data_i;
    ex_d.rs2_data  = bus.id_rs2_data_i;
    ex_d.imm       = bus.id_imm_i;
  end

  assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && bus.id_valid_i &&
                    ((ex_q.rd_addr == bus.id_rs1_addr_i) || (ex_q.rd_addr == bus.id_rs2_addr_i));

`ifdef FWD_EN
  assign dep_stall = 1'b0;
`else
  // Without bypassing, a source still in flight in EX or EX/MEM must wait for write-back.
  logic rs1_busy;
  logic rs2_busy;
  assign rs1_busy = (bus.id_rs1_addr_i != '0) &&
                    ((ex_q.valid && ex_q.reg_write && ex_q.rd_addr == bus.id_rs1_addr_i) ||
                     (bus.exmem_reg_write_i && bus.exmem_rd_addr_i == bus.id_rs1_addr_i));
  assign rs2_busy = (bus.id_rs2_addr_i != '0) &&
                    ((ex_q.valid && ex_q.reg_write && ex_q.rd_addr == bus.id_rs2_addr_i) ||
                     (bus.exmem_reg_write_i && bus.exmem_rd_addr_i == bus.id_rs2_addr_i));
  assign dep_stall = bus.id_valid_i && (rs1_busy || rs2_busy);
`endif

  // A flush kills the ID instruction anyway, so holding it would be pointless.
  assign stall = !bus.flush_i && (load_use || dep_stall);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_i || stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  forward_unit #(.EN(FWD_ON)) u_fwd_rs1 (
    .rs_addr         (ex_q.rs1_addr),
    .rs_data         (ex_q.rs1_data),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd_addr   (bus.exmem_rd_addr_i),
    .exmem_data      (bus.exmem_alu_result_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd_addr   (bus.memwb_rd_addr_i),
    .memwb_data      (bus.memwb_wb_data_i),
    .data            (rs1_fwd)
  );

  forward_unit #(.EN(FWD_ON)) u_fwd_rs2 (
    .rs_addr         (ex_q.rs2_addr),
    .rs_data         (ex_q.rs2_data),
    .exmem_reg_write (bus.exmem_reg_write_i),
    .exmem_rd_addr   (bus.exmem_rd_addr_i),
    .exmem_data      (bus.exmem_alu_result_i),
    .memwb_reg_write (bus.memwb_reg_write_i),
    .memwb_rd_addr   (bus.memwb_rd_addr_i),
    .memwb_data      (bus.memwb_wb_data_i),
    .data            (rs2_fwd)
  );

  assign bus.stall_o         = stall;
  assign bus.ex_valid_o      = ex_q.valid;
  assign bus.ex_alu_op_o     = ex_q.alu_op;
  assign bus.ex_a_o          = rs1_fwd;
  assign bus.ex_b_o          = ex_q.alu_src ? ex_q.imm : rs2_fwd;
  assign bus.ex_store_data_o = rs2_fwd;
  assign bus.ex_rd_addr_o    = ex_q.rd_addr;
  assign bus.ex_mem_read_o   = ex_q.mem_read;
  assign bus.ex_reg_write_o  = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed hazard scenarios plus random
// traffic compared every cycle against an instruction-level model (FWD_EN selects mode).
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   check_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model: the instruction sitting in EX, as a plain record.
  typedef struct {
    bit          valid;
    bit [4:0]    rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    bit [3:0]    op;
    bit          src, ld, wr;
  } instr_t;

  instr_t m_ex = '{default: 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // A source is busy if the instruction producing it has not yet written the register file.
  function automatic bit src_waits(input bit [4:0] s);
    if (s == 0) return 1'b0;
    if (m_ex.valid && m_ex.ld && m_ex.rd == s) return 1'b1;
`ifndef FWD_EN
    if (m_ex.valid && m_ex.wr && m_ex.rd == s) return 1'b1;
    if (bus.exmem_reg_write_i && bus.exmem_rd_addr_i == s) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    if (bus.flush_i || !bus.id_valid_i) return 1'b0;
    return src_waits(bus.id_rs1_addr_i) || src_waits(bus.id_rs2_addr_i);
  endfunction

  // Newest in-flight value of a register, else what the register file returned at ID.
  function automatic logic [31:0] model_operand(input bit [4:0] idx, input logic [31:0] regval);
`ifdef FWD_EN
    if (idx == 0) return regval;
    if (bus.exmem_reg_write_i && bus.exmem_rd_addr_i == idx) return bus.exmem_alu_result_i;
    if (bus.memwb_reg_write_i && bus.memwb_rd_addr_i == idx) return bus.memwb_wb_data_i;
`endif
    return regval;
  endfunction

  always @(posedge clk) begin
    if (reset || bus.flush_i || model_stall()) begin
      m_ex = '{default: 0};
    end else begin
      m_ex.valid = bus.id_valid_i;
      m_ex.rs1   = bus.id_rs1_addr_i;
      m_ex.rs2   = bus.id_rs2_addr_i;
      m_ex.rd    = bus.id_rd_addr_i;
      m_ex.v1    = bus.id_rs1_data_i;
      m_ex.v2    = bus.id_rs2_data_i;
      m_ex.imm   = bus.id_imm_i;
      m_ex.op    = bus.id_alu_op_i;
      m_ex.src   = bus.id_alu_src_i;
      m_ex.ld    = bus.id_mem_read_i;
      m_ex.wr    = bus.id_reg_write_i;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] ea, es;
      ea = model_operand(m_ex.rs1, m_ex.v1);
      es = model_operand(m_ex.rs2, m_ex.v2);
      check("stall",      {31'b0, bus.stall_o},        {31'b0, model_stall()});
      check("ex_valid",   {31'b0, bus.ex_valid_o},     {31'b0, m_ex.valid});
      check("ex_alu_op",  {28'b0, bus.ex_alu_op_o},    {28'b0, m_ex.op});
      check("ex_a",       bus.ex_a_o,                  ea);
      check("ex_b",       bus.ex_b_o,                  m_ex.src ? m_ex.imm : es);
      check("ex_store",   bus.ex_store_data_o,         es);
      check("ex_rd",      {27'b0, bus.ex_rd_addr_o},   {27'b0, m_ex.rd});
      check("ex_mem_rd",  {31'b0, bus.ex_mem_read_o},  {31'b0, m_ex.ld});
      check("ex_reg_wr",  {31'b0, bus.ex_reg_write_o}, {31'b0, m_ex.wr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input bit [3:0] op, input bit src, input bit ld, input bit wr);
    bus.id_valid_i     = v;
    bus.id_rs1_addr_i  = rs1;
    bus.id_rs2_addr_i  = rs2;
    bus.id_rd_addr_i   = rd;
    bus.id_rs1_data_i  = d1;
    bus.id_rs2_data_i  = d2;
    bus.id_imm_i       = imm;
    bus.id_alu_op_i    = op;
    bus.id_alu_src_i   = src;
    bus.id_mem_read_i  = ld;
    bus.id_reg_write_i = wr;
  endtask

  task automatic set_exmem(input bit wr, input bit [4:0] rd, input logic [31:0] res);
    bus.exmem_reg_write_i  = wr;
    bus.exmem_rd_addr_i    = rd;
    bus.exmem_alu_result_i = res;
  endtask

  task automatic set_memwb(input bit wr, input bit [4:0] rd, input logic [31:0] dat);
    bus.memwb_reg_write_i = wr;
    bus.memwb_rd_addr_i   = rd;
    bus.memwb_wb_data_i   = dat;
  endtask

  task automatic idle();
    bus.flush_i = 1'b0;
    set_id(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(0, 5'd0, 32'h0);
  endtask

  initial begin
    // Reset with ID presenting a valid instruction.
    reset = 1'b1;
    idle();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222, 32'h7, 4'h1, 0, 0, 1);
    tick();
    tick();
    check_en = 1'b1;
    @(negedge clk);
    check("rst ex_valid", {31'b0, bus.ex_valid_o}, 32'h0);
    check("rst ex_a", bus.ex_a_o, 32'h0);
    check("rst ex_rd", {27'b0, bus.ex_rd_addr_o}, 32'h0);
    check("rst stall", {31'b0, bus.stall_o}, 32'h0);
    reset = 1'b0;
    tick();
    check("first capture valid", {31'b0, bus.ex_valid_o}, 32'h1);
    check("first capture a", bus.ex_a_o, 32'h1111);
    check("first capture op", {28'b0, bus.ex_alu_op_o}, 32'h1);
    idle();
    tick();
    tick();

`ifdef FWD_EN
    // ADD x3,x1,x2 then ADD x4,x3,x3 with x3 in EX/MEM.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'hB, 32'h0, 4'h0, 0, 0, 1);
    tick();
    set_id(1, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    #1 check("raw no stall", {31'b0, bus.stall_o}, 32'h0);
    tick();
    idle();
    set_exmem(1, 5'd3, 32'h10);
    #1;
    check("fwd exmem a", bus.ex_a_o, 32'h10);
    check("fwd exmem b", bus.ex_b_o, 32'h10);
    tick();

    // x5 in both EX/MEM and MEM/WB; rd=x0 never forwarded.
    idle();
    set_id(1, 5'd5, 5'd0, 5'd8, 32'h11, 32'h33, 32'h0, 4'h2, 0, 0, 1);
    tick();
    idle();
    set_exmem(1, 5'd5, 32'hAA);
    set_memwb(1, 5'd5, 32'hBB);
    #1 check("exmem beats memwb", bus.ex_a_o, 32'hAA);
    set_exmem(1, 5'd0, 32'hFF);
    set_memwb(1, 5'd0, 32'hEE);
    #1;
    check("x0 not fwd b", bus.ex_b_o, 32'h33);
    check("x0 case a", bus.ex_a_o, 32'h11);
    tick();

    // Load-use: LW x6 in EX, ID reads x6.
    idle();
    set_id(1, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h4, 4'h0, 1, 1, 1);
    tick();
    set_id(1, 5'd6, 5'd2, 5'd7, 32'h0, 32'h22, 32'h0, 4'h0, 0, 0, 1);
    #1 check("load-use stall", {31'b0, bus.stall_o}, 32'h1);
    tick();
    set_exmem(1, 5'd6, 32'h104);
    #1;
    check("bubble valid", {31'b0, bus.ex_valid_o}, 32'h0);
    check("stall one cycle", {31'b0, bus.stall_o}, 32'h0);
    tick();
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(1, 5'd6, 32'hDEADBEEF);
    #1;
    check("memwb load data a", bus.ex_a_o, 32'hDEADBEEF);
    check("after load b", bus.ex_b_o, 32'h22);
    tick();
`else
    // Back-to-back dependent ADDs without bypassing.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'hB, 32'h0, 4'h0, 0, 0, 1);
    tick();
    set_id(1, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    #1 check("dep stall ex", {31'b0, bus.stall_o}, 32'h1);
    tick();
    set_exmem(1, 5'd3, 32'h10);
    #1 check("dep stall exmem", {31'b0, bus.stall_o}, 32'h1);
    tick();
    set_exmem(0, 5'd0, 32'h0);
    set_memwb(1, 5'd3, 32'h10);
    set_id(1, 5'd3, 5'd3, 5'd4, 32'h10, 32'h10, 32'h0, 4'h0, 0, 0, 1);
    #1 check("dep released", {31'b0, bus.stall_o}, 32'h0);
    tick();
    idle();
    set_exmem(1, 5'd3, 32'hAA);
    #1;
    check("no fwd a", bus.ex_a_o, 32'h10);
    check("no fwd b", bus.ex_b_o, 32'h10);
    tick();

    // rd = x0 in EX never blocks an x0 read.
    set_id(1, 5'd1, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    tick();
    set_id(1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    #1 check("x0 no stall", {31'b0, bus.stall_o}, 32'h0);
    tick();
`endif

    // Flush together with a load-use hazard.
    idle();
    set_id(1, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h4, 4'h0, 1, 1, 1);
    tick();
    set_id(1, 5'd6, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 1);
    bus.flush_i = 1'b1;
    #1 check("flush hides stall", {31'b0, bus.stall_o}, 32'h0);
    tick();
    bus.flush_i = 1'b0;
    #1 check("flush bubble", {31'b0, bus.ex_valid_o}, 32'h0);
    idle();
    tick();

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      bus.flush_i = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      set_exmem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      set_memwb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    reset = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
